mem_wb_stage: RTL and testbench

//  Memory + write-back stage; the producing end of the ID stage's register-file

---
 rtl/mem_wb_stage.sv | 179 +++++++++++++++++
 tb/tb_mem_wb_stage.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
// Memory + write-back stage: multi-cycle data-memory access, one register write per op.
// Optional feature: define MISALIGN_TRAP_EN to trap memory ops with alu_result[1:0]!=0.
module mem_wb_stage #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned MEM_DEPTH   = 64,
  parameter int unsigned MEM_BASE    = 1024,
  parameter int unsigned MEM_LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              wb_en_in,
  input  logic              mem_read_in,
  input  logic              mem_write_in,
  input  logic [4:0]        dest_in,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] store_val,
  output logic              freeze,
  output logic              write_en,
  output logic [4:0]        dest_address,
  output logic [DATA_W-1:0] write_value
`ifdef MISALIGN_TRAP_EN
  ,
  output logic              misaligned
`endif
);

  localparam int unsigned IDX_W = $clog2(MEM_DEPTH);
  localparam int unsigned CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  typedef enum logic {S_IDLE, S_ACCESS} state_t;

  state_t             r_state;
  state_t             w_state_nx;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nx;

  logic               r_freeze;
  logic               r_we;
  logic [4:0]         r_dest;
  logic [DATA_W-1:0]  r_val;

  // op latched for the duration of ACCESS
  logic               r_op_wb;
  logic               r_op_ld;
  logic [4:0]         r_op_dest;
  logic [IDX_W-1:0]   r_op_idx;
  logic [DATA_W-1:0]  r_op_sval;

  logic [DATA_W-1:0]  r_mem [MEM_DEPTH];

  logic [DATA_W-1:0]  w_off;
  logic [IDX_W-1:0]   w_in_idx;
  logic               w_mem_op;
  logic               w_misal;
  logic               w_latch;
  logic               w_ret;
  logic               w_ret_wb;
  logic               w_ret_ld;
  logic               w_ret_st;
  logic [4:0]         w_ret_dest;
  logic [IDX_W-1:0]   w_ret_idx;
  logic [DATA_W-1:0]  w_ret_sval;
  logic [DATA_W-1:0]  w_rd_data;
  logic               w_we_nx;
  logic [DATA_W-1:0]  w_val_nx;
  logic               w_frz_nx;
  logic               w_mis_nx;
  logic               w_unused;

  assign w_off    = alu_result - DATA_W'(MEM_BASE);
  assign w_in_idx = w_off[IDX_W+1:2];
  assign w_mem_op = mem_read_in | mem_write_in;
  assign w_unused = ^w_off;

`ifdef MISALIGN_TRAP_EN
  assign w_misal = (alu_result[1:0] != 2'b00);
`else
  assign w_misal = 1'b0;
`endif

  // next-state, retire selection and next output values
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_latch    = 1'b0;
    w_ret      = 1'b0;
    w_mis_nx   = 1'b0;
    w_ret_wb   = wb_en_in;
    w_ret_ld   = mem_read_in & ~mem_write_in;
    w_ret_st   = mem_write_in;
    w_ret_dest = dest_in;
    w_ret_idx  = w_in_idx;
    w_ret_sval = store_val;
    unique case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          if (w_mem_op && w_misal) begin
            w_mis_nx = 1'b1;
          end else if (w_mem_op && (MEM_LATENCY > 1)) begin
            w_state_nx = S_ACCESS;
            w_cnt_nx   = CNT_W'(MEM_LATENCY - 1);
            w_latch    = 1'b1;
          end else begin
            w_ret = 1'b1;
          end
        end
      end
      S_ACCESS: begin
        w_ret_wb   = r_op_wb;
        w_ret_ld   = r_op_ld;
        w_ret_st   = ~r_op_ld;
        w_ret_dest = r_op_dest;
        w_ret_idx  = r_op_idx;
        w_ret_sval = r_op_sval;
        if (r_cnt == CNT_W'(1)) begin
          w_state_nx = S_IDLE;
          w_ret      = 1'b1;
        end else begin
          w_cnt_nx = r_cnt - CNT_W'(1);
        end
      end
    endcase
    w_rd_data = r_mem[w_ret_idx];
    w_we_nx   = w_ret & w_ret_wb & ~w_ret_st & (w_ret_dest != 5'd0);
    w_val_nx  = w_ret_ld ? w_rd_data : alu_result;
    w_frz_nx  = (w_state_nx == S_ACCESS);
  end

  // state and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_freeze <= 1'b0;
      r_we     <= 1'b0;
      r_dest   <= '0;
      r_val    <= '0;
    end else begin
      r_state  <= w_state_nx;
      r_cnt    <= w_cnt_nx;
      r_freeze <= w_frz_nx;
      r_we     <= w_we_nx;
      if (w_we_nx) begin
        r_dest <= w_ret_dest;
        r_val  <= w_val_nx;
      end
    end
  end

  // op capture and memory array; neither is reset
  always_ff @(posedge clk) begin
    if (w_latch) begin
      r_op_wb   <= wb_en_in;
      r_op_ld   <= mem_read_in & ~mem_write_in;
      r_op_dest <= dest_in;
      r_op_idx  <= w_in_idx;
      r_op_sval <= store_val;
    end
    if (!rst && w_ret && w_ret_st) begin
      r_mem[w_ret_idx] <= w_ret_sval;
    end
  end

`ifdef MISALIGN_TRAP_EN
  logic r_mis;
  always_ff @(posedge clk) begin
    if (rst) r_mis <= 1'b0;
    else     r_mis <= w_mis_nx;
  end
  assign misaligned = r_mis;
`endif

  assign freeze       = r_freeze;
  assign write_en     = r_we;
  assign dest_address = r_dest;
  assign write_value  = r_val;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed ops, per-cycle model compare,
// literal spot checks.
module tb_mem_wb_stage;
  localparam int LAT   = 2;
  localparam int DEPTH = 64;
  localparam int BASE  = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, wb_en_in, mem_read_in, mem_write_in;
  logic [4:0]  dest_in;
  logic [31:0] alu_result, store_val;
  logic        freeze, write_en;
  logic [4:0]  dest_address;
  logic [31:0] write_value;
`ifdef MISALIGN_TRAP_EN
  logic        misaligned;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_wb_stage #(.DATA_W(32), .MEM_DEPTH(DEPTH), .MEM_BASE(BASE), .MEM_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .wb_en_in(wb_en_in),
    .mem_read_in(mem_read_in), .mem_write_in(mem_write_in), .dest_in(dest_in),
    .alu_result(alu_result), .store_val(store_val), .freeze(freeze),
    .write_en(write_en), .dest_address(dest_address), .write_value(write_value)
`ifdef MISALIGN_TRAP_EN
    , .misaligned(misaligned)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_mem [DEPTH];
  logic        e_we, e_frz, e_mis, m_ready;
  logic [4:0]  e_dest;
  logic [31:0] e_val;
  int          busy = 0;
  logic        p_wb, p_ld;
  logic [4:0]  p_dest;
  logic [31:0] p_addr, p_sval;

  initial m_ready = 1'b0;

  function automatic int widx(input logic [31:0] a);
    return int'(((a - 32'(BASE)) >> 2) % 32'(DEPTH));
  endfunction

  task automatic retire(input logic wb, input logic ld, input logic st,
                        input logic [4:0] d, input logic [31:0] a, input logic [31:0] sv);
    if (st) m_mem[widx(a)] = sv;
    else if (wb && d != 5'd0) begin
      e_we   = 1'b1;
      e_dest = d;
      e_val  = ld ? m_mem[widx(a)] : a;
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      e_we = 0; e_frz = 0; e_mis = 0; e_dest = 0; e_val = 0; busy = 0;
    end else begin
      e_we = 0; e_mis = 0;
      if (busy > 0) begin
        busy--;
        if (busy == 0) retire(p_wb, p_ld, !p_ld, p_dest, p_addr, p_sval);
      end else if (in_valid) begin
        if (mem_read_in || mem_write_in) begin
`ifdef MISALIGN_TRAP_EN
          if (alu_result[1:0] != 2'b00) e_mis = 1;
          else
`endif
          begin
            p_wb = wb_en_in; p_ld = mem_read_in && !mem_write_in;
            p_dest = dest_in; p_addr = alu_result; p_sval = store_val;
            if (LAT > 1) busy = LAT - 1;
            else retire(p_wb, p_ld, !p_ld, p_dest, p_addr, p_sval);
          end
        end else begin
          retire(wb_en_in, 1'b0, 1'b0, dest_in, alu_result, store_val);
        end
      end
      e_frz = (busy > 0);
    end
    m_ready = 1'b1;
  end

  // per-cycle compare against the model
  always @(negedge clk) begin
    if (m_ready) begin
      chk("m_freeze", 32'(freeze), 32'(e_frz));
      chk("m_write_en", 32'(write_en), 32'(e_we));
      chk("m_dest", 32'(dest_address), 32'(e_dest));
      chk("m_value", write_value, e_val);
`ifdef MISALIGN_TRAP_EN
      chk("m_misaligned", 32'(misaligned), 32'(e_mis));
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic op(input logic wb, input logic rd, input logic wr,
                    input logic [4:0] d, input logic [31:0] a, input logic [31:0] sv);
    int n = 0;
    while (freeze && n < 50) begin
      in_valid = 0;
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("freeze_timeout", 32'(freeze), 32'd0);
    in_valid = 1; wb_en_in = wb; mem_read_in = rd; mem_write_in = wr;
    dest_in = d; alu_result = a; store_val = sv;
    @(negedge clk);
    in_valid = 0; mem_read_in = 0; mem_write_in = 0;
  endtask

  initial begin
    rst = 1; in_valid = 0; wb_en_in = 0; mem_read_in = 0; mem_write_in = 0;
    dest_in = 0; alu_result = 0; store_val = 0;
    repeat (3) @(negedge clk);
    chk("rst_freeze", 32'(freeze), 32'd0);
    chk("rst_we", 32'(write_en), 32'd0);
    chk("rst_dest", 32'(dest_address), 32'd0);
    chk("rst_val", write_value, 32'd0);
    rst = 0;
    @(negedge clk);

    // 1: ALU op
    op(1, 0, 0, 5'd5, 32'h1234, 0);
    chk("t1_we", 32'(write_en), 32'd1);
    chk("t1_dest", 32'(dest_address), 32'd5);
    chk("t1_val", write_value, 32'h1234);
    chk("t1_freeze", 32'(freeze), 32'd0);
    @(negedge clk);
    chk("t1_pulse_end", 32'(write_en), 32'd0);

    // 2: store then load same address
    op(0, 0, 1, 5'd0, 32'd1028, 32'hDEADBEEF);
    chk("t2_st_freeze", 32'(freeze), 32'd1);
    chk("t2_st_we", 32'(write_en), 32'd0);
    @(negedge clk);
    chk("t2_st_ret_we", 32'(write_en), 32'd0);
    op(1, 1, 0, 5'd7, 32'd1028, 0);
    chk("t2_ld_freeze", 32'(freeze), 32'd1);
    @(negedge clk);
    chk("t2_ld_we", 32'(write_en), 32'd1);
    chk("t2_ld_dest", 32'(dest_address), 32'd7);
    chk("t2_ld_val", write_value, 32'hDEADBEEF);

    // 3: back-to-back ALU ops
    for (int i = 1; i <= 4; i++) begin
      op(1, 0, 0, 5'(i), 32'(100 + i), 0);
      chk("t3_we", 32'(write_en), 32'd1);
      chk("t3_dest", 32'(dest_address), 32'(i));
      chk("t3_val", write_value, 32'(100 + i));
    end
    @(negedge clk);

    // 4: dest 0 never writes
    op(1, 0, 0, 5'd0, 32'h55, 0);
    chk("t4_we", 32'(write_en), 32'd0);
    chk("t4_dest_hold", 32'(dest_address), 32'd4);

    // 5: address wraps onto word 0
    op(0, 0, 1, 5'd0, 32'(BASE + 4 * DEPTH), 32'hCAFEF00D);
    op(1, 1, 0, 5'd9, 32'(BASE), 0);
    @(negedge clk);
    chk("t5_we", 32'(write_en), 32'd1);
    chk("t5_val", write_value, 32'hCAFEF00D);

    // 6: reset during ACCESS aborts the store
    op(0, 0, 1, 5'd0, 32'd1032, 32'h11111111);
    op(0, 0, 1, 5'd0, 32'd1032, 32'h22222222);
    chk("t6_in_access", 32'(freeze), 32'd1);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("t6_freeze", 32'(freeze), 32'd0);
    chk("t6_we", 32'(write_en), 32'd0);
    chk("t6_dest", 32'(dest_address), 32'd0);
    chk("t6_val", write_value, 32'd0);
    @(negedge clk);
    op(1, 1, 0, 5'd3, 32'd1032, 0);
    @(negedge clk);
    chk("t6_ld_we", 32'(write_en), 32'd1);
    chk("t6_ld_val", write_value, 32'h11111111);

`ifdef MISALIGN_TRAP_EN
    @(negedge clk);
    op(1, 1, 0, 5'd4, 32'd1025, 0);
    chk("t6_mis", 32'(misaligned), 32'd1);
    chk("t6_mis_we", 32'(write_en), 32'd0);
    chk("t6_mis_freeze", 32'(freeze), 32'd0);
    @(negedge clk);
    chk("t6_mis_end", 32'(misaligned), 32'd0);
`endif

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
